// File: rtl/wb_pkg.sv
// Shared constants for the writeback register-file write path.
// Write-select encodings, FSM states and matrix beat count derivation.
package wb_pkg;

    localparam logic [1:0] W_SEL_NONE   = 2'b00;
    localparam logic [1:0] W_SEL_SCALAR = 2'b01;
    localparam logic [1:0] W_SEL_MATRIX = 2'b10;
    localparam logic [1:0] W_SEL_RSVD   = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_ASSEMBLE
    } wb_state_t;

    function automatic int wb_beats(input int xlen, input int mlen);
        return mlen / xlen;
    endfunction

endpackage

// File: rtl/matrix_beat_packer.sv
// Packs XLEN-wide matrix beats into one MLEN-wide word, lane 0 first.
// mat_data already includes the beat being presented this cycle.
module matrix_beat_packer
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int MLEN  = 128,
    parameter int BEATS = wb_beats(XLEN, MLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            restart,
    input  logic [XLEN-1:0] data,
    output logic            last,
    output logic [MLEN-1:0] mat_data
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [XLEN-1:0] lanes [BEATS];
    logic [CW-1:0]   cnt;

    assign last = (cnt == CW'(BEATS - 1));

    always_comb begin
        mat_data = '0;
        for (int i = 0; i < BEATS; i++) begin
            mat_data[i*XLEN +: XLEN] = (CW'(i) == cnt) ? data : lanes[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BEATS; i++) lanes[i] <= '0;
            cnt <= '0;
        end else if (load) begin
            if (restart) begin
                // A restart drops any partial word before taking lane 0.
                for (int i = 1; i < BEATS; i++) lanes[i] <= '0;
                lanes[0] <= data;
                cnt      <= CW'(1);
            end else begin
                lanes[cnt] <= data;
                cnt        <= last ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/wb_matrix_writer.sv
// Writeback producer for scalar and matrix register-file writes.
// Optional WB_FWD_EN adds same-cycle forwarding ports mirroring the write.
module wb_matrix_writer
    import wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MLEN    = 128,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_w_select,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_mem2reg,
    input  logic [XLEN-1:0]    in_alu_data,
    input  logic [XLEN-1:0]    in_mem_data,
    output logic [1:0]         w_select,
    output logic [RADDR_W-1:0] w_regs_addr,
    output logic [XLEN-1:0]    w_regs_data,
    output logic [MLEN-1:0]    w_matrix_data,
    output logic               mat_busy,
    output logic [RADDR_W-1:0] mat_busy_rd,
    output logic               err_sticky
`ifdef WB_FWD_EN
    ,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]    fwd_scalar,
    output logic [MLEN-1:0]    fwd_matrix
`endif
);

    localparam int BEATS = wb_beats(XLEN, MLEN);

    wb_state_t       state;
    logic            fire;
    logic            is_scalar;
    logic            is_beat;
    logic            is_rsvd;
    logic            rd_switch;
    logic            pk_restart;
    logic            pk_last;
    logic            done;
    logic [MLEN-1:0] pk_data;

    assign fire       = in_valid & in_ready;
    assign is_scalar  = fire && (in_w_select == W_SEL_SCALAR);
    assign is_beat    = fire && (in_w_select == W_SEL_MATRIX);
    assign is_rsvd    = fire && (in_w_select == W_SEL_RSVD);
    assign rd_switch  = (in_rd != mat_busy_rd);
    assign pk_restart = is_beat && ((state == S_IDLE) || rd_switch);
    assign done       = is_beat && !pk_restart && pk_last;

    matrix_beat_packer #(
        .XLEN  (XLEN),
        .MLEN  (MLEN),
        .BEATS (BEATS)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .load     (is_beat),
        .restart  (pk_restart),
        .data     (in_mem_data),
        .last     (pk_last),
        .mat_data (pk_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            in_ready      <= 1'b0;
            w_select      <= W_SEL_NONE;
            w_regs_addr   <= '0;
            w_regs_data   <= '0;
            w_matrix_data <= '0;
            mat_busy      <= 1'b0;
            mat_busy_rd   <= '0;
            err_sticky    <= 1'b0;
        end else begin
            in_ready <= 1'b1;
            w_select <= W_SEL_NONE;
            if (is_rsvd || (is_beat && state == S_ASSEMBLE && rd_switch)) begin
                err_sticky <= 1'b1;
            end
            // x0 is hardwired in the scalar file, so writes to it are dropped.
            if (is_scalar && in_rd != '0) begin
                w_select    <= W_SEL_SCALAR;
                w_regs_addr <= in_rd;
                w_regs_data <= in_mem2reg ? in_mem_data : in_alu_data;
            end
            if (is_beat) begin
                if (done) begin
                    w_select      <= W_SEL_MATRIX;
                    w_regs_addr   <= mat_busy_rd;
                    w_matrix_data <= pk_data;
                    state         <= S_IDLE;
                    mat_busy      <= 1'b0;
                    mat_busy_rd   <= '0;
                end else begin
                    state       <= S_ASSEMBLE;
                    mat_busy    <= 1'b1;
                    mat_busy_rd <= in_rd;
                end
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid  = (w_select != W_SEL_NONE);
    assign fwd_rd     = w_regs_addr;
    assign fwd_scalar = w_regs_data;
    assign fwd_matrix = w_matrix_data;
`endif

endmodule

// File: tb/tb_wb_matrix_writer.sv
// Scoreboard bench for wb_matrix_writer with a queue-based reference model.
// Covers scalar, matrix, interleave, rd switch, reserved select and reset.
module tb_wb_matrix_writer;
    import wb_pkg::*;

    localparam int XLEN  = 32;
    localparam int MLEN  = 128;
    localparam int RW    = 5;
    localparam int BEATS = MLEN / XLEN;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_w_select = '0;
    logic [RW-1:0]   in_rd = '0;
    logic            in_mem2reg = 1'b0;
    logic [XLEN-1:0] in_alu_data = '0;
    logic [XLEN-1:0] in_mem_data = '0;
    logic [1:0]      w_select;
    logic [RW-1:0]   w_regs_addr;
    logic [XLEN-1:0] w_regs_data;
    logic [MLEN-1:0] w_matrix_data;
    logic            mat_busy;
    logic [RW-1:0]   mat_busy_rd;
    logic            err_sticky;
`ifdef WB_FWD_EN
    logic            fwd_valid;
    logic [RW-1:0]   fwd_rd;
    logic [XLEN-1:0] fwd_scalar;
    logic [MLEN-1:0] fwd_matrix;
`endif

    wb_matrix_writer #(.XLEN(XLEN), .MLEN(MLEN), .RADDR_W(RW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_w_select   (in_w_select),
        .in_rd         (in_rd),
        .in_mem2reg    (in_mem2reg),
        .in_alu_data   (in_alu_data),
        .in_mem_data   (in_mem_data),
        .w_select      (w_select),
        .w_regs_addr   (w_regs_addr),
        .w_regs_data   (w_regs_data),
        .w_matrix_data (w_matrix_data),
        .mat_busy      (mat_busy),
        .mat_busy_rd   (mat_busy_rd),
        .err_sticky    (err_sticky)
`ifdef WB_FWD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_scalar    (fwd_scalar),
        .fwd_matrix    (fwd_matrix)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      sel;
        logic [RW-1:0]   addr;
        logic [XLEN-1:0] sdata;
        logic [MLEN-1:0] mdata;
    } wr_t;

    wr_t             expq[$];
    logic [XLEN-1:0] part[$];
    logic [RW-1:0]   part_rd = '0;
    bit              m_err = 1'b0;
    bit              exp_ready = 1'b0;
    int              n_chk = 0;
    int              n_pass = 0;

    task automatic chk(input string name, input logic [MLEN-1:0] act,
                       input logic [MLEN-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of pending beats per in-flight matrix register.
    function automatic void model_step(input logic [1:0] sel, input logic [RW-1:0] rd,
                                       input logic m2r, input logic [XLEN-1:0] alu,
                                       input logic [XLEN-1:0] mem);
        wr_t w;
        w = '0;
        if (sel == 2'b01) begin
            if (rd != 0) begin
                w.sel = 2'b01; w.addr = rd; w.sdata = m2r ? mem : alu;
                expq.push_back(w);
            end
        end else if (sel == 2'b10) begin
            if (part.size() != 0 && rd != part_rd) begin
                m_err = 1'b1;
                part.delete();
            end
            part.push_back(mem);
            part_rd = rd;
            if (part.size() == BEATS) begin
                w.sel = 2'b10; w.addr = rd;
                for (int i = 0; i < BEATS; i++) w.mdata[i*XLEN +: XLEN] = part[i];
                expq.push_back(w);
                part.delete();
            end
        end else if (sel == 2'b11) begin
            m_err = 1'b1;
        end
    endfunction

    task automatic scramble();
        in_valid    = 1'b0;
        in_w_select = 2'($urandom);
        in_rd       = RW'($urandom);
        in_mem2reg  = 1'($urandom);
        in_alu_data = $urandom;
        in_mem_data = $urandom;
    endtask

    task automatic xfer(input logic [1:0] sel, input logic [RW-1:0] rd, input logic m2r,
                        input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem);
        in_valid = 1'b1; in_w_select = sel; in_rd = rd;
        in_mem2reg = m2r; in_alu_data = alu; in_mem_data = mem;
        @(posedge clk);
        model_step(sel, rd, m2r, alu, mem);
        #1 scramble();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 scramble();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_ready = 1'b0;
        expq.delete();
        part.delete();
        m_err = 1'b0;
        @(negedge clk);
        chk("rst_addr", MLEN'(w_regs_addr), '0);
        chk("rst_sdata", MLEN'(w_regs_data), '0);
        chk("rst_mdata", w_matrix_data, '0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        exp_ready = 1'b1;
        #1;
    endtask

    // Monitor: one expected write per cycle at most, otherwise w_select must idle.
    always @(negedge clk) begin
        wr_t e;
        bit  has;
        has = (expq.size() > 0);
        e = '0;
        if (has) e = expq.pop_front();
        chk("w_select", MLEN'(w_select), MLEN'(e.sel));
        if (has) begin
            chk("w_addr", MLEN'(w_regs_addr), MLEN'(e.addr));
            if (e.sel == W_SEL_SCALAR) chk("w_sdata", MLEN'(w_regs_data), MLEN'(e.sdata));
            else chk("w_mdata", w_matrix_data, e.mdata);
        end
        chk("mat_busy", MLEN'(mat_busy), MLEN'(part.size() != 0));
        chk("mat_busy_rd", MLEN'(mat_busy_rd), (part.size() != 0) ? MLEN'(part_rd) : '0);
        chk("err_sticky", MLEN'(err_sticky), MLEN'(m_err));
        chk("in_ready", MLEN'(in_ready), MLEN'(exp_ready));
`ifdef WB_FWD_EN
        chk("fwd_valid", MLEN'(fwd_valid), MLEN'(has));
        if (has) begin
            chk("fwd_rd", MLEN'(fwd_rd), MLEN'(e.addr));
            if (e.sel == W_SEL_SCALAR) chk("fwd_scalar", MLEN'(fwd_scalar), MLEN'(e.sdata));
            else chk("fwd_matrix", fwd_matrix, e.mdata);
        end
`endif
    end

    initial begin
        logic [RW-1:0] cur;
        int r;
        #1;
        do_reset();

        xfer(2'b01, 5'd5, 1'b0, 32'h1234, 32'hdead);
        @(negedge clk);
        chk("t1_data", MLEN'(w_regs_data), MLEN'(32'h1234));
        #1 idle(2);

        for (int i = 0; i < 4; i++) xfer(2'b10, 5'd3, 1'b0, 32'h0, 32'hA0 + i);
        @(negedge clk);
        chk("t2_mat", w_matrix_data, 128'h000000A3_000000A2_000000A1_000000A0);
        #1 idle(1);

        xfer(2'b10, 5'd2, 1'b0, 0, 32'hB0);
        xfer(2'b10, 5'd2, 1'b0, 0, 32'hB1);
        xfer(2'b01, 5'd7, 1'b0, 32'h55, 0);
        xfer(2'b10, 5'd2, 1'b0, 0, 32'hB2);
        xfer(2'b10, 5'd2, 1'b0, 0, 32'hB3);
        xfer(2'b01, 5'd0, 1'b1, 32'h77, 32'h88);
        idle(2);

        xfer(2'b10, 5'd4, 1'b0, 0, 32'hC0);
        xfer(2'b10, 5'd4, 1'b0, 0, 32'hC1);
        for (int i = 0; i < 4; i++) xfer(2'b10, 5'd6, 1'b0, 0, 32'hD0 + i);
        @(negedge clk);
        chk("t4_err", MLEN'(err_sticky), MLEN'(1));
        #1 idle(1);

        do_reset();
        xfer(2'b10, 5'd9, 1'b0, 0, 32'hE0);
        xfer(2'b10, 5'd9, 1'b0, 0, 32'hE1);
        do_reset();
        for (int i = 0; i < 4; i++) xfer(2'b10, 5'd0, 1'b1, 0, 32'hF0 + i);
        xfer(2'b11, 5'd1, 1'b0, 0, 0);
        idle(2);
        do_reset();

        cur = RW'($urandom);
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50) xfer(2'b10, cur, 1'($urandom), $urandom, $urandom);
            else if (r < 54) xfer(2'b10, RW'($urandom), 1'($urandom), $urandom, $urandom);
            else if (r < 80) xfer(2'b01, RW'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                                  1'($urandom), $urandom, $urandom);
            else if (r < 82) xfer(2'b11, RW'($urandom), 1'($urandom), $urandom, $urandom);
            else if (r < 92) xfer(2'b00, RW'($urandom), 1'($urandom), $urandom, $urandom);
            else if (r < 99) idle(1);
            else do_reset();
            if ($urandom_range(0, 19) == 0) cur = RW'($urandom);
        end
        idle(3);
        chk("expq_empty", MLEN'(expq.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
